// File: rtl/nac_insn_assembler_pkg.sv
// Shared definitions for the NAC instruction assembler.
//   NAC_MAX_OPERANDS : default operand capacity of an instruction
//   len_cls_e        : opcode[7:6] length classes
//   state_e          : assembler FSM states
//   opc_class()      : extracts the length class from an opcode byte
package nac_insn_assembler_pkg;

  localparam int NAC_MAX_OPERANDS = 8;

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,  // no operands
    CLS_ONE  = 2'b01,  // one operand
    CLS_TWO  = 2'b10,  // two operands
    CLS_EXPL = 2'b11   // next byte carries the operand count
  } len_cls_e;

  typedef enum logic [2:0] {
    ST_OPC  = 3'd0,
    ST_LEN  = 3'd1,
    ST_OPER = 3'd2,
    ST_OUT  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  function automatic len_cls_e opc_class(input logic [7:0] opc);
    return len_cls_e'(opc[7:6]);
  endfunction

endpackage

// File: rtl/nac_len_decode.sv
// Combinational length decoder for the NAC instruction assembler.
// The same incoming byte is interpreted both as an opcode and as an
// explicit-length byte; the FSM picks whichever view matches its state.
//   byte_i    : byte returned by the fetcher
//   cls_o     : length class when byte_i is an opcode
//   opc_cnt_o : implied operand count for classes 00/01/10 (0 for 11)
//   len_cnt_o : operand count when byte_i is an explicit length byte
//   len_err_o : explicit length is illegal (upper nibble set or > MAX)
module nac_len_decode
  import nac_insn_assembler_pkg::*;
#(
  parameter int MAX_OPERANDS = NAC_MAX_OPERANDS
) (
  input  logic [7:0] byte_i,
  output len_cls_e   cls_o,
  output logic [3:0] opc_cnt_o,
  output logic [3:0] len_cnt_o,
  output logic       len_err_o
);

  always_comb begin
    cls_o = opc_class(byte_i);
    unique case (cls_o)
      CLS_ONE: opc_cnt_o = 4'd1;
      CLS_TWO: opc_cnt_o = 4'd2;
      default: opc_cnt_o = 4'd0;
    endcase
    len_cnt_o = byte_i[3:0];
    len_err_o = (byte_i[7:4] != 4'd0) || (int'(byte_i[3:0]) > MAX_OPERANDS);
  end

endmodule

// File: rtl/nac_insn_assembler.sv
// NAC instruction assembler: pulls bytes one at a time from the byte
// fetcher, builds opcode + 0..MAX_OPERANDS operands and hands the result
// to the execution FSM over valid/ready.
// Optional feature macro: NAC_INSN_PC_EN adds the insn_pc port and a byte
// PC loaded from start_addr on flush.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   flush                 : abort current instruction (shared with fetcher)
//   start_addr            : flush target address (PC feature only)
//   fetch_busy            : fetcher has no byte available, hold requests
//   byte_req / byte_data / byte_valid : one-byte request/response
//   insn_valid / insn_ready           : instruction handshake
//   insn_opcode, insn_len, insn_operands : assembled instruction
//   insn_err              : one-cycle pulse on illegal explicit length
//   insn_pc               : opcode byte address (NAC_INSN_PC_EN)
module nac_insn_assembler
  import nac_insn_assembler_pkg::*;
#(
  parameter int MAX_OPERANDS = NAC_MAX_OPERANDS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [31:0]               start_addr,
  input  logic                      fetch_busy,
  output logic                      byte_req,
  input  logic [7:0]                byte_data,
  input  logic                      byte_valid,
  output logic                      insn_valid,
  input  logic                      insn_ready,
  output logic [7:0]                insn_opcode,
  output logic [3:0]                insn_len,
  output logic [8*MAX_OPERANDS-1:0] insn_operands,
  output logic                      insn_err
`ifdef NAC_INSN_PC_EN
  ,
  output logic [31:0]               insn_pc
`endif
);

  state_e   state_q, state_d;
  logic     out_q, out_d;      // a byte request is outstanding
  logic     req_q, req_d;
  logic     err_q, err_d;
  logic [7:0] opc_q, opc_d;
  logic [3:0] len_q, len_d;
  logic [3:0] rem_q, rem_d;
  logic [MAX_OPERANDS-1:0][7:0] ops_q, ops_d;

  len_cls_e   cls;
  logic [3:0] opc_cnt, len_cnt, idx;
  logic       len_err, bv;

  nac_len_decode #(.MAX_OPERANDS(MAX_OPERANDS)) u_len_decode (
    .byte_i    (byte_data),
    .cls_o     (cls),
    .opc_cnt_o (opc_cnt),
    .len_cnt_o (len_cnt),
    .len_err_o (len_err)
  );

  // Only a byte answering our own request counts; stray valids and the
  // flush-cycle byte are dropped.
  assign bv  = byte_valid && out_q && !flush;
  assign idx = len_q - rem_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_OPC;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_OPC;
    end else begin
      unique case (state_q)
        ST_OPC: if (bv) begin
          unique case (cls)
            CLS_NONE: state_d = ST_OUT;
            CLS_EXPL: state_d = ST_LEN;
            default:  state_d = ST_OPER;
          endcase
        end
        ST_LEN: if (bv) begin
          if (len_err)              state_d = ST_ERR;
          else if (len_cnt == 4'd0) state_d = ST_OUT;
          else                      state_d = ST_OPER;
        end
        ST_OPER: if (bv && rem_q == 4'd1) state_d = ST_OUT;
        ST_OUT:  if (insn_ready) state_d = ST_OPC;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_OPC;
      endcase
    end
  end

  // Output logic
  always_comb begin
    insn_valid = (state_q == ST_OUT);
  end

  // Datapath / request next-state
  always_comb begin
    opc_d = opc_q;
    len_d = len_q;
    rem_d = rem_q;
    ops_d = ops_q;
    err_d = 1'b0;
    // Request is decided from the next state so a new byte can be asked
    // for in the same cycle the previous one lands (one byte / 2 cycles).
    req_d = !flush && !fetch_busy && (!out_q || bv) &&
            (state_d inside {ST_OPC, ST_LEN, ST_OPER});
    out_d = out_q;
    if (bv)    out_d = 1'b0;
    if (req_d) out_d = 1'b1;
    if (flush) begin
      out_d = 1'b0;
      len_d = 4'd0;
      rem_d = 4'd0;
      ops_d = '0;
    end else begin
      unique case (state_q)
        ST_OPC: if (bv) begin
          opc_d = byte_data;
          len_d = opc_cnt;
          rem_d = opc_cnt;
        end
        ST_LEN: if (bv) begin
          if (len_err) begin
            err_d = 1'b1;
          end else begin
            len_d = len_cnt;
            rem_d = len_cnt;
          end
        end
        ST_OPER: if (bv) begin
          for (int i = 0; i < MAX_OPERANDS; i++)
            if (idx == 4'(i)) ops_d[i] = byte_data;
          if (rem_q != 4'd0) rem_d = rem_q - 4'd1;
        end
        ST_OUT: if (insn_ready) ops_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      req_q <= 1'b0;
      err_q <= 1'b0;
      opc_q <= 8'd0;
      len_q <= 4'd0;
      rem_q <= 4'd0;
      ops_q <= '0;
    end else begin
      out_q <= out_d;
      req_q <= req_d;
      err_q <= err_d;
      opc_q <= opc_d;
      len_q <= len_d;
      rem_q <= rem_d;
      ops_q <= ops_d;
    end
  end

  assign byte_req      = req_q;
  assign insn_err      = err_q;
  assign insn_opcode   = opc_q;
  assign insn_len      = len_q;
  assign insn_operands = ops_q;

`ifdef NAC_INSN_PC_EN
  logic [31:0] pc_q, ipc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= 32'd0;
      ipc_q <= 32'd0;
    end else if (flush) begin
      pc_q <= start_addr;
    end else if (bv) begin
      pc_q <= pc_q + 32'd1;
      if (state_q == ST_OPC) ipc_q <= pc_q;
    end
  end

  assign insn_pc = ipc_q;
`else
  logic unused_start_addr;
  assign unused_start_addr = ^start_addr;
`endif

endmodule
